dino_game_ctrl: RTL

Top-level game sequencer for the dino runner. It owns the game-step tick and the jump/ground state machine, and generates and scrolls obstacles. It detects collisions, keeps the score, and drives the same 16-bit two-row `grid` display bus as `dino_mov`. It sits between the push-button input and the display driver, replacing free-running movement with a start / run / game-over sequence.

---
 rtl/dino_pkg.sv | 24 ++
 rtl/dino_obstacle_gen.sv | 64 ++++++
 rtl/dino_game_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dino_pkg.sv
// Shared types and constants for the dino runner game sequencer.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_AIR  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam int DINO_COL = 0;
  localparam int UP_HI    = 15;
  localparam int UP_LO    = 8;
  localparam int DN_HI    = 7;
  localparam int DN_LO    = 0;

  // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dino_obstacle_gen.sv
// Obstacle source: LFSR-driven spawn decision, spawn spacing counter and the
// 8-column obstacle row that scrolls toward the dino on every game step.
module dino_obstacle_gen
  import dino_pkg::*;
#(
  parameter int         MIN_GAP   = 5,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       step,
  output logic [7:0] obs,
  output logic       spawn
);

  localparam int GAP_W = $clog2(MIN_GAP + 1);

  logic [7:0]       obs_q, obs_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             spawn_s;

  // Spawn decision and next-row computation for the current step
  always_comb begin
    spawn_s = (lfsr_q[1:0] == 2'b11) && (gap_q >= GAP_W'(MIN_GAP));
    obs_d   = obs_q;
    lfsr_d  = lfsr_q;
    gap_d   = gap_q;
    if (clear) begin
      obs_d = 8'h00;
      gap_d = '0;
    end else if (step) begin
      obs_d  = {spawn_s, obs_q[7:1]};
      lfsr_d = lfsr_next(lfsr_q);
      if (spawn_s) begin
        gap_d = '0;
      end else if (gap_q >= GAP_W'(MIN_GAP)) begin
        gap_d = GAP_W'(MIN_GAP);
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end else begin
      obs_d = obs_q;
    end
  end

  // The LFSR is only reseeded by reset so each new game sees a fresh pattern
  always_ff @(posedge clk) begin
    if (reset) begin
      obs_q  <= 8'h00;
      lfsr_q <= LFSR_SEED;
      gap_q  <= '0;
    end else begin
      obs_q  <= obs_d;
      lfsr_q <= lfsr_d;
      gap_q  <= gap_d;
    end
  end

  assign obs   = obs_q;
  assign spawn = spawn_s;

endmodule

// File: rtl/dino_game_ctrl.sv
// Dino runner sequencer: step tick, press edge detect, IDLE/RUN/AIR/OVER FSM,
// collision check, saturating score and the two-row grid display bus.
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int         TICK_DIV   = 25_000_000,
  parameter int         JUMP_TICKS = 3,
  parameter int         MIN_GAP    = 5,
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  parameter int         SCORE_W    = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               jump_button,
  output logic [15:0]        grid,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic [1:0]         state
);

  localparam int TICK_W = $clog2(TICK_DIV);

  state_e             state_q, state_d;
  logic               jump_q;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [3:0]         air_q, air_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [15:0]        grid_q, grid_d;
  logic               game_over_q, game_over_d;

  logic       press_s, step_s, clear_s, spawn_s, collide_s;
  logic [7:0] obs_s, obs_next_s;

  assign press_s = jump_button & ~jump_q;
  assign step_s  = ((state_q == ST_RUN) || (state_q == ST_AIR)) &&
                   (tick_q == TICK_W'(TICK_DIV - 1));
  assign clear_s = (state_q == ST_IDLE) && press_s;

  dino_obstacle_gen #(
    .MIN_GAP   (MIN_GAP),
    .LFSR_SEED (LFSR_SEED)
  ) u_obstacle_gen (
    .clk   (clk),
    .reset (reset),
    .clear (clear_s),
    .step  (step_s),
    .obs   (obs_s),
    .spawn (spawn_s)
  );

  // Next-cycle obstacle row, so collision and grid use post-step values
  always_comb begin
    if (clear_s) begin
      obs_next_s = 8'h00;
    end else if (step_s) begin
      obs_next_s = {spawn_s, obs_s[7:1]};
    end else begin
      obs_next_s = obs_s;
    end
  end

  // FSM next state, tick counter, jump timer and score
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    air_d     = air_q;
    score_d   = score_q;
    collide_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_s) begin
          state_d = ST_RUN;
          tick_d  = '0;
          score_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        tick_d = step_s ? '0 : tick_q + TICK_W'(1);
        // A press coinciding with a step counts that step as the first airborne one
        if (press_s) begin
          state_d = ST_AIR;
          air_d   = (step_s && (JUMP_TICKS > 1)) ? 4'(JUMP_TICKS - 1) : 4'(JUMP_TICKS);
        end else if (step_s && obs_next_s[DINO_COL]) begin
          state_d   = ST_OVER;
          collide_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_AIR: begin
        tick_d = step_s ? '0 : tick_q + TICK_W'(1);
        if (step_s && (air_q == 4'd1)) begin
          air_d = 4'd0;
          if (obs_next_s[DINO_COL]) begin
            state_d   = ST_OVER;
            collide_s = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else if (step_s) begin
          air_d = air_q - 4'd1;
        end else begin
          air_d = air_q;
        end
      end
      ST_OVER: begin
        if (press_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (step_s && !collide_s && (score_q != {SCORE_W{1'b1}})) begin
      score_d = score_q + SCORE_W'(1);
    end else begin
      score_d = score_d;
    end
  end

  // Display composition from the next state; frozen while staying in OVER
  always_comb begin
    grid_d = 16'h0001;
    case (state_d)
      ST_IDLE: grid_d = 16'h0001;
      ST_RUN: begin
        grid_d[UP_HI:UP_LO] = 8'h00;
        grid_d[DN_HI:DN_LO] = obs_next_s | 8'h01;
      end
      ST_AIR: begin
        grid_d[UP_HI:UP_LO] = 8'h01;
        grid_d[DN_HI:DN_LO] = obs_next_s;
      end
      ST_OVER: begin
        if (state_q == ST_OVER) begin
          grid_d = grid_q;
        end else begin
          grid_d[UP_HI:UP_LO] = 8'h00;
          grid_d[DN_HI:DN_LO] = obs_next_s | 8'h01;
        end
      end
      default: grid_d = 16'h0001;
    endcase
    game_over_d = (state_d == ST_OVER);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      jump_q      <= 1'b0;
      tick_q      <= '0;
      air_q       <= 4'd0;
      score_q     <= '0;
      grid_q      <= 16'h0001;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      jump_q      <= jump_button;
      tick_q      <= tick_d;
      air_q       <= air_d;
      score_q     <= score_d;
      grid_q      <= grid_d;
      game_over_q <= game_over_d;
    end
  end

  assign grid      = grid_q;
  assign score     = score_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule
